// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result {remainder, quotient}.
// Optional DIV_FAST_SMALL_EN: early exit when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [2:0] {FREE, ZERO, ON, FIN, END} state_t;

  localparam logic [5:0] LAST = 6'(DATA_W);

  state_t              state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   dvd;
  logic [DATA_W-1:0]   dvs;
  logic                s1, s2;

  logic                neg1, neg2;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   q_fin, r_fin;

  always_comb begin
    neg1  = signed_div_i & opdata1_i[DATA_W-1];
    neg2  = signed_div_i & opdata2_i[DATA_W-1];
    abs1  = neg1 ? -opdata1_i : opdata1_i;
    abs2  = neg2 ? -opdata2_i : opdata2_i;
    diff  = {1'b0, dvd[2*DATA_W-1:DATA_W]} - {1'b0, dvs};
    q_fin = (s1 ^ s2) ? -dvd[DATA_W-1:0] : dvd[DATA_W-1:0];
    r_fin = s1 ? -dvd[2*DATA_W:DATA_W+1] : dvd[2*DATA_W:DATA_W+1];
  end

`ifdef DIV_FAST_SMALL_EN
  logic small_op;
  always_comb small_op = (abs1 < abs2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            s1  <= neg1;
            s2  <= neg2;
            dvs <= abs2;
            cnt <= '0;
            if (opdata2_i == '0) begin
              state <= ZERO;
`ifdef DIV_FAST_SMALL_EN
            end else if (small_op) begin
              // Park the original signed dividend where the remainder is read out.
              dvd   <= {opdata1_i, {DATA_W{1'b0}}, 1'b0};
              state <= FIN;
`endif
            end else begin
              dvd   <= {{DATA_W{1'b0}}, abs1, 1'b0};
              state <= ON;
            end
          end
        end
        ZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= END;
        end
        FIN: begin
          result_o <= {dvd[2*DATA_W:DATA_W+1], {DATA_W{1'b0}}};
          ready_o  <= 1'b1;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            cnt   <= '0;
            state <= FREE;
          end else if (cnt != LAST) begin
            if (diff[DATA_W])
              dvd <= {dvd[2*DATA_W-1:0], 1'b0};
            else
              dvd <= {diff[DATA_W-1:0], dvd[DATA_W-1:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {r_fin, q_fin};
            ready_o  <= 1'b1;
            cnt      <= '0;
            state    <= END;
          end
        end
        END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
            state    <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue, compared at ready.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return '0;
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb;
    if (b == 32'd0) return 2;
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
`ifdef DIV_FAST_SMALL_EN
    if (la < lb) return 2;
`endif
    return 34;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, scramble operands after sampling, wait (bounded) for ready.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    int lat;
    logic [63:0] e;
    exp_q.push_back(model(s, a, b));
    lat = exp_lat(s, a, b);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
    end while (!ready_o && n < 200);
    check("latency", 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check("result", result_o, e);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      check("hold_result", result_o, e);
    end
    start_i = 1'b0;
    step();
    check("drop_ready", {63'd0, ready_o}, 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (ready_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    step(); step();
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    step();

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(1'b0, 32'd12345, 32'd0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(1'b0, 32'd3, 32'd10, 0);
    run_div(1'b1, 32'hFFFF_FFFD, 32'd10, 0);
    run_div(1'b0, 32'd1000, 32'd33, 5);

    // Annul mid-ON: no result may ever appear, then an immediate new start.
    signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd3; start_i = 1'b1;
    step();
    repeat (9) step();
    annul_i = 1'b1; start_i = 1'b0;
    step();
    annul_i = 1'b0;
    watch_idle("annul_no_ready", 40);
    run_div(1'b0, 32'd9, 32'd3, 0);

    // annul together with start in FREE must not launch anything.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1; annul_i = 1'b1;
    watch_idle("annul_start_free", 3);
    start_i = 1'b0; annul_i = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 0);

    // Reset mid-ON aborts.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (5) step();
    rst = 1'b1; start_i = 1'b0;
    step();
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    watch_idle("rst_abort", 40);

    for (int k = 0; k < 8; k++) begin
      logic [31:0] a, b;
      logic s;
      s = 1'($urandom_range(0, 1));
      a = (k < 4) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      b = (k < 4) ? ($urandom >> $urandom_range(0, 31)) : 32'($signed($urandom_range(0, 40)) - 20);
      run_div(s, a, b, k % 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
